// File: rtl/bypass_scoreboard_if.sv
// Decode/execute bus between the pipeline and the bypass scoreboard.
interface bypass_scoreboard_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned REG_BITS   = 5,
    parameter int unsigned STAGES     = 3,
    parameter int unsigned CNT_WIDTH  = 16
);
    localparam int unsigned SELW = $clog2(STAGES + 1);

    // Decode slot tags
    logic                               flush;
    logic                               id_valid;
    logic [REG_BITS-1:0]                id_rs1;
    logic [REG_BITS-1:0]                id_rs2;
    logic                               id_use_rs1;
    logic                               id_use_rs2;
    logic [REG_BITS-1:0]                id_rd;
    logic                               id_wr_en;
    logic                               id_is_load;

    // Stage results and register-file operands for the X instruction
    logic [(STAGES-1)*DATA_WIDTH-1:0]   stage_data;
    logic [DATA_WIDTH-1:0]              ex_rf_a;
    logic [DATA_WIDTH-1:0]              ex_rf_b;

    // Forwarding and interlock results
    logic [DATA_WIDTH-1:0]              ex_op_a;
    logic [DATA_WIDTH-1:0]              ex_op_b;
    logic [SELW-1:0]                    fwd_sel_a;
    logic [SELW-1:0]                    fwd_sel_b;
    logic                               stall;
    logic                               ex_valid;
    logic [CNT_WIDTH-1:0]               stall_count;

    // Pipeline side: supplies tags and data, consumes operands and stall
    modport master (
        output flush, id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_wr_en, id_is_load, stage_data, ex_rf_a, ex_rf_b,
        input  ex_op_a, ex_op_b, fwd_sel_a, fwd_sel_b, stall, ex_valid,
               stall_count
    );

    // Scoreboard side
    modport slave (
        input  flush, id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_wr_en, id_is_load, stage_data, ex_rf_a, ex_rf_b,
        output ex_op_a, ex_op_b, fwd_sel_a, fwd_sel_b, stall, ex_valid,
               stall_count
    );
endinterface

// File: rtl/bypass_scoreboard.sv
// Forwarding and load-use interlock unit: a shifting board of destination
// tags for stages 1..STAGES drives operand bypass into X and the load-use
// stall toward fetch/decode, and counts stall cycles.
module bypass_scoreboard #(
    parameter int unsigned DATA_WIDTH       = 32,
    parameter int unsigned REG_BITS         = 5,
    parameter int unsigned STAGES           = 3,
    parameter int unsigned LOAD_READY_STAGE = 3,
    parameter int unsigned ZERO_REG         = 1,
    parameter int unsigned CNT_WIDTH        = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    bypass_scoreboard_if.slave   bus
);
    localparam int unsigned SELW = $clog2(STAGES + 1);

    typedef struct packed {
        logic                valid;
        logic                wr;
        logic [REG_BITS-1:0] rd;
        logic                load;
    } entry_t;

    typedef struct packed {
        logic                use1;
        logic [REG_BITS-1:0] rs1;
        logic                use2;
        logic [REG_BITS-1:0] rs2;
    } srcTags_t;

    entry_t [STAGES:1]       board;
    srcTags_t                exSrc;
    logic   [STAGES:1]       live;
    logic   [CNT_WIDTH-1:0]  stallCount;

    entry_t                  issueEntry;
    srcTags_t                issueSrc;
    logic                    issue;
    logic                    hazard1;
    logic                    hazard2;
    logic                    shadow1;
    logic                    shadow2;
    logic                    stallNow;

    logic [SELW-1:0]         selA;
    logic [SELW-1:0]         selB;
    logic [DATA_WIDTH-1:0]   opA;
    logic [DATA_WIDTH-1:0]   opB;
    logic                    foundA;
    logic                    foundB;

    // An entry is live when it will really write a register; r0 is ignored when hardwired
    always_comb begin
        live = '0;
        for (int unsigned k = 1; k <= STAGES; k++) begin
            live[k] = board[k].valid && board[k].wr &&
                      !((ZERO_REG != 0) && (board[k].rd == '0));
        end
    end

    // Load-use hazard: the youngest live writer of each source decides; only a load too young to forward stalls
    always_comb begin
        hazard1 = 1'b0;
        hazard2 = 1'b0;
        shadow1 = 1'b0;
        shadow2 = 1'b0;
        for (int unsigned j = 1; j <= STAGES; j++) begin
            if (live[j] && (board[j].rd == bus.id_rs1)) begin
                if (!shadow1 && board[j].load && (j + 1 < LOAD_READY_STAGE)) begin
                    hazard1 = 1'b1;
                end
                shadow1 = 1'b1;
            end
            if (live[j] && (board[j].rd == bus.id_rs2)) begin
                if (!shadow2 && board[j].load && (j + 1 < LOAD_READY_STAGE)) begin
                    hazard2 = 1'b1;
                end
                shadow2 = 1'b1;
            end
        end
        stallNow = bus.id_valid && !bus.flush &&
                   ((bus.id_use_rs1 && hazard1) || (bus.id_use_rs2 && hazard2));
    end

    // Tags entering stage 1; a stalled or flushed decode slot becomes a bubble
    always_comb begin
        issue            = bus.id_valid && !stallNow && !bus.flush;
        issueEntry       = '0;
        issueEntry.valid = 1'b1;
        issueEntry.wr    = bus.id_wr_en;
        issueEntry.rd    = bus.id_rd;
        issueEntry.load  = bus.id_is_load;
        issueSrc         = '0;
        issueSrc.use1    = bus.id_use_rs1;
        issueSrc.rs1     = bus.id_rs1;
        issueSrc.use2    = bus.id_use_rs2;
        issueSrc.rs2     = bus.id_rs2;
    end

    // Operand bypass: the nearest (youngest) live writer in stages 2..STAGES wins
    always_comb begin
        selA   = '0;
        selB   = '0;
        opA    = bus.ex_rf_a;
        opB    = bus.ex_rf_b;
        foundA = 1'b0;
        foundB = 1'b0;
        for (int unsigned k = 2; k <= STAGES; k++) begin
            if (!foundA && exSrc.use1 && live[k] && (board[k].rd == exSrc.rs1)) begin
                foundA = 1'b1;
                selA   = SELW'(k);
                opA    = bus.stage_data[(k-2)*DATA_WIDTH +: DATA_WIDTH];
            end
            if (!foundB && exSrc.use2 && live[k] && (board[k].rd == exSrc.rs2)) begin
                foundB = 1'b1;
                selB   = SELW'(k);
                opB    = bus.stage_data[(k-2)*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Board shift, X source tags and saturating stall counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            board      <= '0;
            exSrc      <= '0;
            stallCount <= '0;
        end else begin
            board[1] <= issue ? issueEntry : entry_t'('0);
            for (int unsigned k = 2; k <= STAGES; k++) begin
                board[k] <= board[k-1];
            end
            exSrc <= issue ? issueSrc : srcTags_t'('0);
            if (stallNow && (stallCount != '1)) begin
                stallCount <= stallCount + CNT_WIDTH'(1);
            end
        end
    end

    assign bus.stall       = stallNow;
    assign bus.ex_valid    = board[1].valid;
    assign bus.stall_count = stallCount;
    assign bus.fwd_sel_a   = selA;
    assign bus.fwd_sel_b   = selB;
    assign bus.ex_op_a     = opA;
    assign bus.ex_op_b     = opB;

endmodule

// File: tb/tb_bypass_scoreboard.sv
// Bench for bypass_scoreboard: default 3-stage and deep 5-stage instances,
// directed scenarios plus random instruction streams against a model that
// tracks the issued-instruction history by age.
module tb_bypass_scoreboard;

    typedef struct packed {
        logic       valid;
        logic       wr;
        logic       load;
        logic       use1;
        logic       use2;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } instr_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    instr_t      curId;
    logic        curFl;
    logic [31:0] rfA;
    logic [31:0] rfB;
    logic [31:0] sd [2:5];

    int          nChecks = 0;
    int          nFails  = 0;

    // Reference model: pipe[0] is the instruction now in X, pipe[k-1] is in stage k
    instr_t      pipe [$];
    int          mStages;
    int          mLrs;
    int          mCount;
    logic        curStall;
    bit          selB;

    bypass_scoreboard_if #(.DATA_WIDTH(32), .REG_BITS(5), .STAGES(3), .CNT_WIDTH(16)) busA ();
    bypass_scoreboard_if #(.DATA_WIDTH(32), .REG_BITS(5), .STAGES(5), .CNT_WIDTH(16)) busB ();

    bypass_scoreboard #(
        .DATA_WIDTH(32), .REG_BITS(5), .STAGES(3), .LOAD_READY_STAGE(3),
        .ZERO_REG(1), .CNT_WIDTH(16)
    ) dutA (
        .clock (clock),
        .reset (reset),
        .bus   (busA)
    );

    bypass_scoreboard #(
        .DATA_WIDTH(32), .REG_BITS(5), .STAGES(5), .LOAD_READY_STAGE(5),
        .ZERO_REG(1), .CNT_WIDTH(16)
    ) dutB (
        .clock (clock),
        .reset (reset),
        .bus   (busB)
    );

    always #5 clock = ~clock;

    // Both instances see the same decode stream
    assign busA.flush      = curFl;
    assign busA.id_valid   = curId.valid;
    assign busA.id_rs1     = curId.rs1;
    assign busA.id_rs2     = curId.rs2;
    assign busA.id_use_rs1 = curId.use1;
    assign busA.id_use_rs2 = curId.use2;
    assign busA.id_rd      = curId.rd;
    assign busA.id_wr_en   = curId.wr;
    assign busA.id_is_load = curId.load;
    assign busA.stage_data = {sd[3], sd[2]};
    assign busA.ex_rf_a    = rfA;
    assign busA.ex_rf_b    = rfB;

    assign busB.flush      = curFl;
    assign busB.id_valid   = curId.valid;
    assign busB.id_rs1     = curId.rs1;
    assign busB.id_rs2     = curId.rs2;
    assign busB.id_use_rs1 = curId.use1;
    assign busB.id_use_rs2 = curId.use2;
    assign busB.id_rd      = curId.rd;
    assign busB.id_wr_en   = curId.wr;
    assign busB.id_is_load = curId.load;
    assign busB.stage_data = {sd[5], sd[4], sd[3], sd[2]};
    assign busB.ex_rf_a    = rfA;
    assign busB.ex_rf_b    = rfB;

    logic        obsStall;
    logic        obsExValid;
    int          obsSelA;
    int          obsSelB;
    logic [31:0] obsOpA;
    logic [31:0] obsOpB;
    logic [15:0] obsCnt;

    assign obsStall   = selB ? busB.stall : busA.stall;
    assign obsExValid = selB ? busB.ex_valid : busA.ex_valid;
    assign obsSelA    = selB ? int'(busB.fwd_sel_a) : int'(busA.fwd_sel_a);
    assign obsSelB    = selB ? int'(busB.fwd_sel_b) : int'(busA.fwd_sel_b);
    assign obsOpA     = selB ? busB.ex_op_a : busA.ex_op_a;
    assign obsOpB     = selB ? busB.ex_op_b : busA.ex_op_b;
    assign obsCnt     = selB ? busB.stall_count : busA.stall_count;

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        nChecks++;
        if (obs !== expv) begin
            nFails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    function automatic instr_t mk(input logic v, input logic w, input int rd, input logic ld,
                                  input logic u1, input int r1, input logic u2, input int r2);
        instr_t i;
        i.valid = v;
        i.wr    = w;
        i.rd    = 5'(rd);
        i.load  = ld;
        i.use1  = u1;
        i.rs1   = 5'(r1);
        i.use2  = u2;
        i.rs2   = 5'(r2);
        return i;
    endfunction

    function automatic instr_t randInstr();
        instr_t i;
        i.valid = ($urandom_range(0, 99) < 85);
        i.wr    = ($urandom_range(0, 99) < 80);
        i.load  = i.wr && ($urandom_range(0, 99) < 35);
        i.use1  = ($urandom_range(0, 99) < 75);
        i.use2  = ($urandom_range(0, 99) < 60);
        i.rd    = 5'($urandom_range(0, 7));
        i.rs1   = 5'($urandom_range(0, 7));
        i.rs2   = 5'($urandom_range(0, 7));
        return i;
    endfunction

    function automatic logic isLive(input instr_t e);
        return e.valid && e.wr && (e.rd != 5'd0);
    endfunction

    // The youngest in-flight writer of rs decides whether its value is still unavailable
    function automatic logic modelHazard(input logic [4:0] rs);
        for (int j = 1; j <= pipe.size() && j <= mStages; j++) begin
            if (isLive(pipe[j-1]) && pipe[j-1].rd == rs) return pipe[j-1].load && (j + 1 < mLrs);
        end
        return 1'b0;
    endfunction

    // Stage number of the youngest writer past X, 0 for the register file
    function automatic int modelFwd(input logic useIt, input logic [4:0] rs);
        if (!useIt) return 0;
        for (int k = 2; k <= pipe.size() && k <= mStages; k++) begin
            if (isLive(pipe[k-1]) && pipe[k-1].rd == rs) return k;
        end
        return 0;
    endfunction

    task automatic drive(input instr_t id, input logic fl);
        curId = id;
        curFl = fl;
        rfA   = $urandom;
        rfB   = $urandom;
        for (int k = 2; k <= 5; k++) sd[k] = $urandom;
    endtask

    task automatic checkOutputs();
        instr_t      x;
        int          ka;
        int          kb;
        logic [31:0] ea;
        logic [31:0] eb;
        #1;
        curStall = curId.valid && !curFl &&
                   ((curId.use1 && modelHazard(curId.rs1)) || (curId.use2 && modelHazard(curId.rs2)));
        x  = (pipe.size() > 0) ? pipe[0] : instr_t'('0);
        ka = modelFwd(x.use1, x.rs1);
        kb = modelFwd(x.use2, x.rs2);
        ea = (ka == 0) ? rfA : sd[ka];
        eb = (kb == 0) ? rfB : sd[kb];
        checkVal("stall", 64'(obsStall), 64'(curStall));
        checkVal("exValid", 64'(obsExValid), 64'(x.valid));
        checkVal("fwdSelA", 64'(obsSelA), 64'(ka));
        checkVal("fwdSelB", 64'(obsSelB), 64'(kb));
        checkVal("exOpA", 64'(obsOpA), 64'(ea));
        checkVal("exOpB", 64'(obsOpB), 64'(eb));
        checkVal("stallCount", 64'(obsCnt), 64'(mCount));
        if (obsSelA >= 2 && obsSelA <= pipe.size() && obsSelA < mLrs)
            checkVal("loadFwdEarlyA", 64'(pipe[obsSelA-1].load), 64'(0));
        if (obsSelB >= 2 && obsSelB <= pipe.size() && obsSelB < mLrs)
            checkVal("loadFwdEarlyB", 64'(pipe[obsSelB-1].load), 64'(0));
    endtask

    task automatic advance();
        @(posedge clock);
        pipe.push_front((curId.valid && !curStall && !curFl) ? curId : instr_t'('0));
        while (pipe.size() > mStages) void'(pipe.pop_back());
        if (curStall && mCount != 65535) mCount++;
        #1;
    endtask

    task automatic step(input instr_t id, input logic fl);
        drive(id, fl);
        checkOutputs();
        advance();
    endtask

    task automatic hardReset();
        reset = 1'b1;
        #1;
        pipe.delete();
        mCount = 0;
        checkVal("rstStall", 64'(obsStall), 64'(0));
        checkVal("rstExValid", 64'(obsExValid), 64'(0));
        checkVal("rstFwdSelA", 64'(obsSelA), 64'(0));
        checkVal("rstFwdSelB", 64'(obsSelB), 64'(0));
        checkVal("rstExOpA", 64'(obsOpA), 64'(rfA));
        checkVal("rstStallCount", 64'(obsCnt), 64'(0));
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic randomRun(input int cycles);
        instr_t id;
        logic   held;
        id = randInstr();
        for (int i = 0; i < cycles; i++) begin
            drive(id, ($urandom_range(0, 9) == 0));
            checkOutputs();
            held = curStall;
            advance();
            if (!held) id = randInstr();
        end
    endtask

    initial begin
        instr_t dep;
        selB    = 1'b0;
        mStages = 3;
        mLrs    = 3;
        mCount  = 0;
        drive(instr_t'('0), 1'b0);
        hardReset();

        // Back-to-back ALU dependency forwarded from M on both operands
        step(mk(1, 1, 3, 0, 1, 1, 1, 2), 1'b0);
        step(mk(1, 1, 8, 0, 1, 3, 1, 3), 1'b0);
        drive(instr_t'('0), 1'b0);
        sd[2] = 32'h0000_0011;
        checkOutputs();
        checkVal("aluSelA", 64'(obsSelA), 64'(2));
        checkVal("aluSelB", 64'(obsSelB), 64'(2));
        checkVal("aluOpA", 64'(obsOpA), 64'h11);
        checkVal("aluOpB", 64'(obsOpB), 64'h11);
        checkVal("aluCount", 64'(obsCnt), 64'(0));
        advance();

        // Younger writer in M beats older one in W
        step(mk(1, 1, 7, 0, 0, 0, 0, 0), 1'b0);
        step(mk(1, 1, 7, 0, 0, 0, 0, 0), 1'b0);
        step(mk(1, 1, 9, 0, 1, 7, 0, 0), 1'b0);
        drive(instr_t'('0), 1'b0);
        sd[3] = 32'h0000_AAAA;
        sd[2] = 32'h0000_BBBB;
        checkOutputs();
        checkVal("prioSelA", 64'(obsSelA), 64'(2));
        checkVal("prioOpA", 64'(obsOpA), 64'h0000_BBBB);
        advance();

        // Writes to r0 are never forwarded
        step(mk(1, 1, 0, 0, 0, 0, 0, 0), 1'b0);
        step(mk(1, 1, 0, 0, 0, 0, 0, 0), 1'b0);
        step(mk(1, 1, 12, 0, 1, 0, 0, 0), 1'b0);
        drive(instr_t'('0), 1'b0);
        checkOutputs();
        checkVal("zeroSelA", 64'(obsSelA), 64'(0));
        checkVal("zeroOpA", 64'(obsOpA), 64'(rfA));
        advance();

        // Load-use: one stall cycle, bubble into X, then forward from W
        step(mk(1, 1, 4, 1, 0, 0, 0, 0), 1'b0);
        dep = mk(1, 1, 1, 0, 1, 4, 1, 2);
        drive(dep, 1'b0);
        checkOutputs();
        checkVal("luStall", 64'(obsStall), 64'(1));
        advance();
        drive(dep, 1'b0);
        checkOutputs();
        checkVal("luBubble", 64'(obsExValid), 64'(0));
        checkVal("luStallOnce", 64'(obsStall), 64'(0));
        advance();
        drive(instr_t'('0), 1'b0);
        checkOutputs();
        checkVal("luSelA", 64'(obsSelA), 64'(3));
        checkVal("luOpA", 64'(obsOpA), 64'(sd[3]));
        checkVal("luCount", 64'(obsCnt), 64'(1));
        advance();

        // Flush beats the stall: no stall, no count, bubble enters X
        step(mk(1, 1, 6, 1, 0, 0, 0, 0), 1'b0);
        drive(mk(1, 1, 10, 0, 1, 6, 0, 0), 1'b1);
        checkOutputs();
        checkVal("flStall", 64'(obsStall), 64'(0));
        advance();
        drive(instr_t'('0), 1'b0);
        checkOutputs();
        checkVal("flExValid", 64'(obsExValid), 64'(0));
        checkVal("flCount", 64'(obsCnt), 64'(1));
        advance();

        // Reset asserted while stalling clears everything before the next edge
        step(mk(1, 1, 5, 1, 0, 0, 0, 0), 1'b0);
        drive(mk(1, 1, 11, 0, 1, 5, 0, 0), 1'b0);
        checkOutputs();
        checkVal("rmsStall", 64'(obsStall), 64'(1));
        hardReset();
        drive(instr_t'('0), 1'b0);
        checkOutputs();
        advance();

        randomRun(300);

        // Deep pipeline: 5 stages, load data ready at stage 5
        selB    = 1'b1;
        mStages = 5;
        mLrs    = 5;
        drive(instr_t'('0), 1'b0);
        hardReset();
        step(mk(1, 1, 9, 1, 0, 0, 0, 0), 1'b0);
        dep = mk(1, 1, 11, 0, 1, 9, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(dep, 1'b0);
            checkOutputs();
            checkVal("deepStall", 64'(obsStall), 64'(1));
            advance();
        end
        drive(dep, 1'b0);
        checkOutputs();
        checkVal("deepRelease", 64'(obsStall), 64'(0));
        advance();
        drive(instr_t'('0), 1'b0);
        checkOutputs();
        checkVal("deepSelA", 64'(obsSelA), 64'(5));
        checkVal("deepOpA", 64'(obsOpA), 64'(sd[5]));
        checkVal("deepCount", 64'(obsCnt), 64'(3));
        advance();

        // A younger ALU write of r9 shadows the load
        step(mk(1, 1, 9, 1, 0, 0, 0, 0), 1'b0);
        step(mk(1, 1, 9, 0, 0, 0, 0, 0), 1'b0);
        drive(dep, 1'b0);
        checkOutputs();
        checkVal("shadowStall", 64'(obsStall), 64'(0));
        advance();
        drive(instr_t'('0), 1'b0);
        checkOutputs();
        checkVal("shadowSelA", 64'(obsSelA), 64'(2));
        advance();

        randomRun(300);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
